// File: rtl/masked_pkg.sv
// Shared constants and types for the masked share generator.
package masked_pkg;

  localparam int unsigned LFSR_W_DEF = 32;
  localparam logic [31:0] TAPS_DEF   = 32'h8020_0003;
  localparam logic [31:0] SEED_DEF   = 32'hACE1_2468;

  typedef enum logic {
    WARMUP,
    RUN
  } state_e;

  typedef struct packed {
    logic a0;
    logic a1;
    logic b0;
    logic b1;
    logic r;
  } share_t;

endpackage

// File: rtl/lfsr_galois_step.sv
// Combinational N-step right-shifting Galois LFSR advance.
module lfsr_galois_step #(
  parameter int unsigned       W     = 32,
  parameter logic [W-1:0]      TAPS  = W'(32'h8020_0003),
  parameter int unsigned       STEPS = 3
) (
  input  logic [W-1:0] state_i,
  output logic [W-1:0] state_o
);

  always_comb begin
    logic [W-1:0] s;
    s = state_i;
    for (int unsigned i = 0; i < STEPS; i++) begin
      s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    end
    state_o = s;
  end

endmodule

// File: rtl/masked_share_gen.sv
// Splits operand bits a/b into two Boolean shares with LFSR masks.
// FRESH_MASK_EN: when defined, r carries a fresh mask and the LFSR advances 3 steps; else r=0, 2 steps.
module masked_share_gen
  import masked_pkg::*;
#(
  parameter int unsigned       LFSR_W        = LFSR_W_DEF,
  parameter logic [LFSR_W-1:0] TAPS          = LFSR_W'(TAPS_DEF),
  parameter logic [LFSR_W-1:0] SEED_DEFAULT  = LFSR_W'(SEED_DEF),
  parameter int unsigned       WARMUP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              a,
  input  logic              b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              a0,
  output logic              a1,
  output logic              b0,
  output logic              b1,
  output logic              r
);

`ifdef FRESH_MASK_EN
  localparam int unsigned ADV_STEPS = 3;
`else
  localparam int unsigned ADV_STEPS = 2;
`endif

  localparam int unsigned    CNT_W      = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP_CYCLES - 1);
  localparam state_e         INIT_STATE = (WARMUP_CYCLES == 0) ? RUN : WARMUP;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_adv;
  share_t            share_q, share_d;
  logic              out_valid_q, out_valid_d;
  logic              accept;

  lfsr_galois_step #(
    .W     (LFSR_W),
    .TAPS  (TAPS),
    .STEPS (ADV_STEPS)
  ) u_step (
    .state_i (lfsr_q),
    .state_o (lfsr_adv)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    share_d     = share_q;
    out_valid_d = out_valid_q;

    in_ready = (state_q == RUN) && !seed_valid && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Masks come from the pre-advance state; accept only happens in RUN.
    if (accept) begin
      share_d.a0  = a ^ lfsr_q[0];
      share_d.a1  = lfsr_q[0];
      share_d.b0  = b ^ lfsr_q[1];
      share_d.b1  = lfsr_q[1];
`ifdef FRESH_MASK_EN
      share_d.r   = lfsr_q[2];
`else
      share_d.r   = 1'b0;
`endif
      out_valid_d = 1'b1;
      lfsr_d      = lfsr_adv;
    end

    if (seed_valid) begin
      lfsr_d  = (seed == '0) ? SEED_DEFAULT : seed;
      cnt_d   = '0;
      state_d = INIT_STATE;
    end else if (state_q == WARMUP) begin
      lfsr_d = lfsr_adv;
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= INIT_STATE;
      cnt_q       <= '0;
      lfsr_q      <= SEED_DEFAULT;
      share_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      share_q     <= share_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign a0        = share_q.a0;
  assign a1        = share_q.a1;
  assign b0        = share_q.b0;
  assign b1        = share_q.b1;
  assign r         = share_q.r;

endmodule

// File: tb/tb_masked_share_gen.sv
// Directed and randomised checks of masked_share_gen with WARMUP_CYCLES of 0 and 16.
module tb_masked_share_gen;

`ifdef FRESH_MASK_EN
  localparam int unsigned STEPS = 3;
`else
  localparam int unsigned STEPS = 2;
`endif
  localparam logic [31:0] TAPS_C = 32'h8020_0003;
  localparam logic [31:0] SEED_C = 32'hACE1_2468;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // DUT with no warmup
  logic        seed_valid, in_valid, a, b, out_ready;
  logic [31:0] seed;
  logic        in_ready, out_valid, a0, a1, b0, b1, r;

  // DUT with 16-cycle warmup
  logic        w_seed_valid, w_in_valid, w_a, w_b, w_out_ready;
  logic [31:0] w_seed;
  logic        w_in_ready, w_out_valid, w_a0, w_a1, w_b0, w_b1, w_r;

  masked_share_gen #(.WARMUP_CYCLES(0)) u_dut (
    .clk(clk), .rstn(rstn), .seed_valid(seed_valid), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .r(r)
  );

  masked_share_gen #(.WARMUP_CYCLES(16)) u_wu (
    .clk(clk), .rstn(rstn), .seed_valid(w_seed_valid), .seed(w_seed),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .a(w_a), .b(w_b),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .a0(w_a0), .a1(w_a1), .b0(w_b0), .b1(w_b1), .r(w_r)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] adv(input logic [31:0] s, input int unsigned n);
    logic [31:0] t;
    t = s;
    for (int unsigned i = 0; i < n; i++) t = t[0] ? ((t >> 1) ^ TAPS_C) : (t >> 1);
    return t;
  endfunction

  function automatic logic [4:0] shares(input logic ia, input logic ib, input logic [31:0] m);
`ifdef FRESH_MASK_EN
    return {ia ^ m[0], m[0], ib ^ m[1], m[1], m[2]};
`else
    return {ia ^ m[0], m[0], ib ^ m[1], m[1], 1'b0};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        a;
    logic        b;
    logic [4:0]  sh;     // {a0,a1,b0,b1,r}
    logic [31:0] lfsr;   // state after the accept
  } vec_t;

  vec_t vt[3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ms, wm;
    logic        mov, acc, exp_rdy, ia, ib;
    logic [4:0]  msh;
    logic        ma, mb;
    int unsigned nacc, iter;

`ifdef FRESH_MASK_EN
    vt[0] = '{a: 1'b1, b: 1'b1, sh: 5'b01100, lfsr: 32'h6018_0001};
    vt[1] = '{a: 1'b0, b: 1'b1, sh: 5'b11100, lfsr: 32'h6C1B_0001};
    vt[2] = '{a: 1'b1, b: 1'b0, sh: 5'b01000, lfsr: 32'h6D9B_6001};
`else
    vt[0] = '{a: 1'b1, b: 1'b1, sh: 5'b01100, lfsr: 32'hC030_0002};
    vt[1] = '{a: 1'b0, b: 1'b1, sh: 5'b00010, lfsr: 32'hB02C_0003};
    vt[2] = '{a: 1'b1, b: 1'b0, sh: 5'b01110, lfsr: 32'h6C1B_0001};
`endif

    rstn = 1'b0;
    {seed_valid, in_valid, a, b, out_ready} = '0;
    seed = '0;
    {w_seed_valid, w_in_valid, w_a, w_b, w_out_ready} = '0;
    w_seed = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_shares", {27'd0, a0, a1, b0, b1, r}, 32'd0);
    chk("rst_lfsr", u_dut.lfsr_q, SEED_C);
    rstn = 1'b1;

    // Warmup: in_ready low for exactly 16 cycles
    for (int i = 0; i <= 16; i++) begin
      chk("warmup_in_ready", {31'd0, w_in_ready}, (i == 16) ? 32'd1 : 32'd0);
      chk("warmup_out_valid", {31'd0, w_out_valid}, 32'd0);
      step();
    end

    // Seed 1 on the no-warmup instance, stays in RUN
    seed_valid = 1'b1; seed = 32'h1; out_ready = 1'b1;
    #1 chk("seed_cycle_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    seed_valid = 1'b0;
    chk("seed1_lfsr", u_dut.lfsr_q, 32'h1);

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = vt[i].a; b = vt[i].b; out_ready = 1'b1;
      #1 chk("vec_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("vec_out_valid", {31'd0, out_valid}, 32'd1);
      chk("vec_shares", {27'd0, a0, a1, b0, b1, r}, {27'd0, vt[i].sh});
      chk("vec_lfsr", u_dut.lfsr_q, vt[i].lfsr);
    end

    // Backpressure with output pending
    a = 1'b0; b = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_shares", {27'd0, a0, a1, b0, b1, r}, {27'd0, vt[2].sh});
      chk("bp_lfsr", u_dut.lfsr_q, vt[2].lfsr);
    end
    out_ready = 1'b1; a = 1'b1; b = 1'b1;
    #1 chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("drain_out_valid", {31'd0, out_valid}, 32'd1);
    chk("drain_shares", {27'd0, a0, a1, b0, b1, r}, {27'd0, shares(1'b1, 1'b1, vt[2].lfsr)});
    chk("drain_lfsr", u_dut.lfsr_q, adv(vt[2].lfsr, STEPS));

    // Zero seed substitutes the default; pending word drains in the same cycle
    in_valid = 1'b1; seed_valid = 1'b1; seed = 32'h0;
    step();
    seed_valid = 1'b0; in_valid = 1'b0;
    chk("seed0_lfsr", u_dut.lfsr_q, SEED_C);
    chk("seed0_out_valid", {31'd0, out_valid}, 32'd0);

    // Random transfers against a cycle model
    ms = SEED_C; mov = 1'b0; msh = '0; ma = 1'b0; mb = 1'b0;
    nacc = 0; iter = 0;
    while (nacc < 1000 && iter < 5000) begin
      iter++;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ia = 1'($urandom_range(0, 1));
      ib = 1'($urandom_range(0, 1));
      a = ia; b = ib;
      exp_rdy = !mov || out_ready;
      #1 chk("rand_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      acc = in_valid && exp_rdy;
      step();
      if (out_ready) mov = 1'b0;
      if (acc) begin
        msh = shares(ia, ib, ms);
        ma = ia; mb = ib;
        mov = 1'b1;
        ms = adv(ms, STEPS);
        nacc++;
      end
      chk("rand_out_valid", {31'd0, out_valid}, {31'd0, mov});
      if (mov) begin
        chk("rand_shares", {27'd0, a0, a1, b0, b1, r}, {27'd0, msh});
        chk("rand_a_recombine", {31'd0, a0 ^ a1}, {31'd0, ma});
        chk("rand_b_recombine", {31'd0, b0 ^ b1}, {31'd0, mb});
`ifndef FRESH_MASK_EN
        chk("rand_r_zero", {31'd0, r}, 32'd0);
`endif
      end
      chk("rand_lfsr", u_dut.lfsr_q, ms);
      chk("rand_lfsr_nonzero", {31'd0, (u_dut.lfsr_q == 32'd0)}, 32'd0);
    end
    chk("rand_accepts", nacc, 32'd1000);
    in_valid = 1'b0;

    // Reseed in RUN with in_valid high and a pending word on the warmup instance
    wm = adv(SEED_C, 16 * STEPS);
    w_in_valid = 1'b1; w_a = 1'b1; w_b = 1'b0; w_out_ready = 1'b0;
    #1 chk("w_accept_ready", {31'd0, w_in_ready}, 32'd1);
    step();
    chk("w_pending_valid", {31'd0, w_out_valid}, 32'd1);
    chk("w_pending_shares", {27'd0, w_a0, w_a1, w_b0, w_b1, w_r}, {27'd0, shares(1'b1, 1'b0, wm)});
    w_seed_valid = 1'b1; w_seed = 32'h1234_5678; w_out_ready = 1'b1;
    #1 chk("reseed_in_ready", {31'd0, w_in_ready}, 32'd0);
    w_out_ready = 1'b0;
    step();
    chk("reseed_lfsr", u_wu.lfsr_q, 32'h1234_5678);
    chk("reseed_pending_valid", {31'd0, w_out_valid}, 32'd1);
    chk("reseed_pending_shares", {27'd0, w_a0, w_a1, w_b0, w_b1, w_r}, {27'd0, shares(1'b1, 1'b0, wm)});
    w_seed_valid = 1'b0; w_out_ready = 1'b1;
    #1 chk("reseed_warmup_ready", {31'd0, w_in_ready}, 32'd0);
    step();
    chk("reseed_drained", {31'd0, w_out_valid}, 32'd0);
    chk("reseed_warmup_lfsr", u_wu.lfsr_q, adv(32'h1234_5678, STEPS));

    // Asynchronous reset mid-transfer
    in_valid = 1'b1; a = 1'b1; b = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_shares", {27'd0, a0, a1, b0, b1, r}, 32'd0);
    chk("async_rst_lfsr", u_dut.lfsr_q, SEED_C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/masked_share_gen.md
Name: masked_share_gen

Overview:
- Upstream stage of the 2-share masked AND gadget.
- Accepts unmasked operand bits a, b over a valid/ready handshake.
- Splits each operand into two Boolean shares using an internal Galois LFSR, and supplies the fresh-mask bit r.
- Presents a0/a1/b0/b1/r from a registered output stage that feeds the gadget's share inputs directly.

Parameters:
LFSR_W, 32, LFSR state width (>= 3)
TAPS, 32'h80200003, Galois feedback polynomial mask (x^32+x^22+x^2+x+1)
SEED_DEFAULT, 32'hACE1_2468, state loaded at reset and when a zero seed is supplied; must be nonzero
WARMUP_CYCLES, 16, LFSR diffusion steps after reset or reseed before accepting data (0 allowed)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
seed_valid  input  1  load seed this cycle
seed  input  LFSR_W  new LFSR seed
in_valid  input  1  operand pair valid
in_ready  output  1  operand pair accepted when in_valid && in_ready
a  input  1  unmasked operand A
b  input  1  unmasked operand B
out_valid  output  1  share set valid
out_ready  input  1  downstream accepts share set
a0  output  1  share A[0] = a ^ ma
a1  output  1  share A[1] = ma
b0  output  1  share B[0] = b ^ mb
b1  output  1  share B[1] = mb
r  output  1  fresh refresh mask mr

Behaviour:
- Clock is clk. Reset is rstn, asynchronous, active-low.
- Reset values:
  - out_valid=0; a0=a1=b0=b1=r=0.
  - LFSR=SEED_DEFAULT; warmup counter=0.
  - FSM=WARMUP, or RUN if WARMUP_CYCLES==0.
- LFSR step is Galois right shift: if state[0] then state=(state>>1)^TAPS, else state=state>>1.
- An "advance" is 3 steps, unrolled combinationally, applied in one cycle.
- Mask bits are taken from the current state before advancing: ma=state[0], mb=state[1], mr=state[2].
- FSM WARMUP:
  - LFSR advances every cycle; counter increments.
  - At count==WARMUP_CYCLES-1, go to RUN and clear the counter.
  - in_ready=0.
- FSM RUN:
  - in_ready = !seed_valid && (!out_valid || out_ready).
  - On accept: register the shares, set out_valid=1, advance the LFSR.
  - The LFSR does not advance without an accept.
- Output stage:
  - One-deep pipeline register; input-to-output latency is 1 cycle.
  - Data and out_valid are held stable while out_valid && !out_ready.
  - out_valid clears on out_ready when there is no simultaneous accept.
  - Simultaneous accept and out_ready delivers back-to-back, one per cycle.
- Reseed (any state):
  - Load seed, or SEED_DEFAULT if seed==0.
  - Clear the counter; go to WARMUP, or RUN if WARMUP_CYCLES==0.
  - seed_valid has priority over in_valid: no accept in that cycle.
  - A pending output word is not dropped and still drains via out_ready.
- LFSR must never reach zero: zero seeds are substituted, and Galois steps from a nonzero state stay nonzero.
- Reset mid-transfer: pending output is discarded and out_valid=0 immediately (asynchronous).

Optional Feature:
- Macro: FRESH_MASK_EN.
- Defined:
  - r = mr, registered with the shares.
  - Advance remains 3 steps per accept.
- Undefined:
  - r output is constant 0, for the gadget build that reuses b shares instead of fresh randomness.
  - Advance is 2 steps per accept and per warmup cycle; mr is unused.
  - All other behaviour is unchanged.

Decomposition:
- Package masked_pkg:
  - LFSR_W default, TAPS and SEED_DEFAULT constants.
  - FSM state enum {WARMUP, RUN}.
  - Typedef for the share bundle struct {a0, a1, b0, b1, r}.
- Sub-module lfsr_galois_step: purely combinational N-step Galois advance, parameterised by width, taps and step count, instantiated once.

Test Plan:
- Reset, then release with WARMUP_CYCLES=16 -> in_ready=0 for exactly 16 cycles, then 1; out_valid=0 throughout.
- WARMUP_CYCLES=0, seed=32'h1, FRESH_MASK_EN defined, a=1 b=1 -> next cycle out_valid=1, a0=0 a1=1 b0=1 b1=0 r=0.
  - LFSR becomes 32'h60180001.
  - Second transfer a=0 b=1 -> a0=1 a1=1 b0=1 b1=0 r=0.
- Backpressure: out_ready=0 for 5 cycles with an output pending -> shares stable, in_ready=0, LFSR unchanged. out_ready=1 -> drains, next accept proceeds.
- seed_valid and in_valid in the same RUN cycle -> no accept, seed loaded, WARMUP entered. A previously pending output still drains.
- seed=0 -> LFSR loads SEED_DEFAULT; 1000 random transfers: a0^a1==a and b0^b1==b on every output, LFSR never 0.
- FRESH_MASK_EN undefined -> r==0 on every output; LFSR advances 2 steps per accept (seed 1 -> 32'hC0300002).
